// File: rtl/dmem_pkg.sv
// Shared encodings for the two-port data-memory controller: access sizes,
// controller states and the default starvation limit for the DMA port.
package dmem_pkg;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RESP = 2'd1,
    RMW_WR    = 2'd2,
    ERR_RESP  = 2'd3
  } state_e;

  // Bytes never fault; halves need an even address; words need a word address.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      default: misaligned = |lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane steering: merges store data into a memory word and extracts /
// extends the addressed lane of a memory word for loads.
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] merged,
  output logic [31:0] ext
);

  logic [4:0]  shamt;
  logic [31:0] lane_mask;
  logic [31:0] shifted;

  always_comb begin
    shamt = {lo, 3'b000};
    case (size)
      SZ_BYTE: lane_mask = 32'h0000_00ff << shamt;
      SZ_HALF: lane_mask = 32'h0000_ffff << shamt;
      default: lane_mask = 32'hffff_ffff;
    endcase
    merged  = (mem_word & ~lane_mask) | ((wdata << shamt) & lane_mask);
    shifted = mem_word >> shamt;
    case (size)
      SZ_BYTE: ext = {{24{~uns & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ext = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default: ext = mem_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port (CPU / DMA) data-memory controller with starvation-limited priority,
// sub-word read-modify-write stores and misalignment error responses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W+1:0] p0_addr,
  input  logic [1:0]        p0_size,
  input  logic              p0_unsigned,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic              p0_wdone,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W+1:0] p1_addr,
  input  logic [1:0]        p1_size,
  input  logic              p1_unsigned,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic              p1_wdone,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              owner_q, owner_d;
  logic              wdone_q, wdone_d;
  logic              we_q, we_d, uns_q, uns_d;
  logic [1:0]        size_q, size_d, lo_q, lo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              can_grant, p1_wins, gnt_any, sel;
  logic              g_we, g_uns, g_mis;
  logic [1:0]        g_size;
  logic [ADDR_W+1:0] g_addr;
  logic [31:0]       g_wdata;
  logic              resp_load, resp_err;
  logic [31:0]       merged, ext;

  // Lane logic always works on the recorded request and the returning word.
  dmem_byte_lane u_lane (
    .mem_word (mem_read_data),
    .wdata    (wdata_q),
    .lo       (lo_q),
    .size     (size_q),
    .uns      (uns_q),
    .merged   (merged),
    .ext      (ext)
  );

  always_comb begin
    can_grant = !reset && (state_q != RMW_WR);
    p1_wins   = p1_req && (!p0_req || (wait_q == CNT_W'(STARVE_LIMIT)));
    p0_gnt    = can_grant && p0_req && !p1_wins;
    p1_gnt    = can_grant && p1_wins;
    gnt_any   = p0_gnt || p1_gnt;
    sel       = p1_wins;
    g_we      = sel ? p1_we       : p0_we;
    g_uns     = sel ? p1_unsigned : p0_unsigned;
    g_size    = sel ? p1_size     : p0_size;
    g_addr    = sel ? p1_addr     : p0_addr;
    g_wdata   = sel ? p1_wdata    : p0_wdata;
    g_mis     = misaligned(g_size, g_addr[1:0]);
  end

  always_comb begin
    state_d        = IDLE;
    wait_d         = wait_q;
    owner_d        = owner_q;
    wdone_d        = 1'b0;
    we_d           = we_q;
    uns_d          = uns_q;
    size_d         = size_q;
    lo_d           = lo_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = g_addr[ADDR_W+1:2];
    mem_write_data = g_wdata;

    if (p1_gnt)
      wait_d = '0;
    else if (p1_req && (wait_q != CNT_W'(STARVE_LIMIT)))
      wait_d = wait_q + 1'b1;

    if (state_q == RMW_WR) begin
      mem_write      = !reset;
      mem_address    = addr_q;
      mem_write_data = merged;
      wdone_d        = !reset;
    end else if (gnt_any) begin
      owner_d = sel;
      we_d    = g_we;
      uns_d   = g_uns;
      size_d  = g_size;
      lo_d    = g_addr[1:0];
      addr_d  = g_addr[ADDR_W+1:2];
      wdata_d = g_wdata;
      if (g_mis) begin
        state_d = ERR_RESP;
      end else if (!g_we) begin
        mem_read = 1'b1;
        state_d  = LOAD_RESP;
      end else if (g_size[1]) begin
        mem_write = 1'b1;
        wdone_d   = 1'b1;
      end else begin
        // Sub-word store: fetch the word now, write the merged word next cycle.
        mem_read = 1'b1;
        state_d  = RMW_WR;
      end
    end
  end

  always_comb begin
    resp_load = (state_q == LOAD_RESP);
    resp_err  = (state_q == ERR_RESP);
    p0_rvalid = !owner_q && (resp_load || (resp_err && !we_q));
    p1_rvalid =  owner_q && (resp_load || (resp_err && !we_q));
    p0_wdone  = !owner_q && (wdone_q || (resp_err && we_q));
    p1_wdone  =  owner_q && (wdone_q || (resp_err && we_q));
    p0_err    = !owner_q && resp_err;
    p1_err    =  owner_q && resp_err;
    p0_rdata  = (!owner_q && resp_load) ? ext : 32'h0;
    p1_rdata  = ( owner_q && resp_load) ? ext : 32'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      owner_q <= 1'b0;
      wdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      owner_q <= owner_d;
      wdone_q <= wdone_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    uns_q   <= uns_d;
    size_q  <= size_d;
    lo_q    <= lo_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dmem_ctrl;

  localparam int ADDR_W = 14;
  localparam int LIMIT  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_unsigned, p1_req, p1_we, p1_unsigned;
  logic [15:0] p0_addr, p1_addr;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_wdone, p0_err;
  logic        p1_gnt, p1_rvalid, p1_wdone, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_read, mem_write;
  logic [13:0] mem_address;
  logic [31:0] mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.STARVE_LIMIT(LIMIT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size),
    .p0_unsigned(p0_unsigned), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_wdone(p0_wdone), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size),
    .p1_unsigned(p1_unsigned), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_wdone(p1_wdone), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  function automatic logic [31:0] init_word(input int a);
    return (a == 5) ? 32'h1122_3344 : 32'hA000_0000 + 32'(a) * 32'h0000_0101;
  endfunction

  // Data memory seen by the DUT.
  logic [31:0] mem [int];
  function automatic logic [31:0] mem_peek(input int a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_read)  mem_read_data <= mem_peek(int'(mem_address));
    if (mem_write) mem[int'(mem_address)] = mem_write_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-cycle schedule of expected response activity.
  typedef struct packed {
    logic        blk;
    logic [1:0]  rv, wd, er;
    logic [31:0] rd0, rd1;
    logic        mw;
    logic [13:0] ma;
    logic [31:0] mwd;
  } slot_t;

  slot_t       sch [3];
  logic [31:0] ref_mem [int];
  int          wcnt = 0;

  function automatic logic [31:0] ref_peek(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  always @(negedge clk) begin : model
    slot_t       cur;
    logic [1:0]  e_gnt;
    logic        e_mr, e_mw, got, w, we, uns;
    logic [13:0] e_ma;
    logic [31:0] e_mwd, wd, word;
    logic [15:0] addr;
    logic [1:0]  size;
    int          nbytes, lo, wa;
    longint      v;

    cur    = sch[0];
    sch[0] = sch[1];
    sch[1] = sch[2];
    sch[2] = '0;
    e_gnt  = '0;
    e_mr   = 1'b0;
    e_mw   = cur.mw;
    e_ma   = cur.ma;
    e_mwd  = cur.mwd;
    got    = 1'b0;
    w      = 1'b0;
    if (reset) begin
      cur    = '0;
      e_mw   = 1'b0;
      sch[0] = '0;
      sch[1] = '0;
      wcnt   = 0;
    end else begin
      if (cur.mw) ref_mem[int'(cur.ma)] = cur.mwd;
      if (!cur.blk) begin
        if (p0_req && !(p1_req && wcnt == LIMIT)) begin got = 1'b1; w = 1'b0; end
        else if (p1_req) begin got = 1'b1; w = 1'b1; end
      end
      if (got) begin
        e_gnt[w] = 1'b1;
        we     = w ? p1_we : p0_we;
        uns    = w ? p1_unsigned : p0_unsigned;
        addr   = w ? p1_addr : p0_addr;
        size   = w ? p1_size : p0_size;
        wd     = w ? p1_wdata : p0_wdata;
        wa     = int'(addr[15:2]);
        lo     = int'(addr[1:0]);
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        word   = ref_peek(wa);
        if (lo % nbytes != 0) begin
          sch[0].er[w] = 1'b1;
          if (we) sch[0].wd[w] = 1'b1;
          else    sch[0].rv[w] = 1'b1;
        end else if (!we) begin
          e_mr = 1'b1;
          e_ma = 14'(wa);
          v = (longint'(word) >> (8 * lo)) % (longint'(1) << (8 * nbytes));
          if (!uns && v >= (longint'(1) << (8 * nbytes - 1)))
            v = v - (longint'(1) << (8 * nbytes));
          sch[0].rv[w] = 1'b1;
          if (w) sch[0].rd1 = 32'(v);
          else   sch[0].rd0 = 32'(v);
        end else if (nbytes == 4) begin
          e_mw  = 1'b1;
          e_ma  = 14'(wa);
          e_mwd = wd;
          ref_mem[wa] = wd;
          sch[0].wd[w] = 1'b1;
        end else begin
          e_mr = 1'b1;
          e_ma = 14'(wa);
          for (int b = 0; b < nbytes; b++) word[8 * (lo + b) +: 8] = wd[8 * b +: 8];
          sch[0].blk   = 1'b1;
          sch[0].mw    = 1'b1;
          sch[0].ma    = 14'(wa);
          sch[0].mwd   = word;
          sch[1].wd[w] = 1'b1;
        end
      end
      if (got && w) wcnt = 0;
      else if (p1_req && wcnt < LIMIT) wcnt++;
    end

    chk("m_p0_gnt", 32'(p0_gnt), 32'(e_gnt[0]));
    chk("m_p1_gnt", 32'(p1_gnt), 32'(e_gnt[1]));
    chk("m_mem_read", 32'(mem_read), 32'(e_mr));
    chk("m_mem_write", 32'(mem_write), 32'(e_mw));
    if (e_mr || e_mw) chk("m_mem_address", 32'(mem_address), 32'(e_ma));
    if (e_mw) chk("m_mem_write_data", mem_write_data, e_mwd);
    chk("m_p0_rvalid", 32'(p0_rvalid), 32'(cur.rv[0]));
    chk("m_p1_rvalid", 32'(p1_rvalid), 32'(cur.rv[1]));
    chk("m_p0_wdone", 32'(p0_wdone), 32'(cur.wd[0]));
    chk("m_p1_wdone", 32'(p1_wdone), 32'(cur.wd[1]));
    chk("m_p0_err", 32'(p0_err), 32'(cur.er[0]));
    chk("m_p1_err", 32'(p1_err), 32'(cur.er[1]));
    chk("m_p0_rdata", p0_rdata, cur.rd0);
    chk("m_p1_rdata", p1_rdata, cur.rd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic we, input logic [15:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd);
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_size = size; p0_unsigned = uns; p0_wdata = wd;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_size = size; p1_unsigned = uns; p1_wdata = wd;
    end
  endtask

  task automatic idle_all();
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  int p1_first;
  int nmr, nrv;

  initial begin
    reset = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_size = '0; p0_unsigned = 1'b0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_size = '0; p1_unsigned = 1'b0; p1_wdata = '0;
    drive(0, 1'b0, 16'h0014, 2'b10, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_p0_gnt", 32'(p0_gnt), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    tick();
    reset = 1'b0;
    idle_all();

    // Signed byte load of the top byte of word 5.
    tick(); drive(0, 1'b0, 16'h0017, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    chk("l031_gnt", 32'(p0_gnt), 32'h1);
    chk("l031_mem_read", 32'(mem_read), 32'h1);
    chk("l031_addr", 32'(mem_address), 32'h5);
    tick(); idle_all();
    @(negedge clk);
    chk("l031_rvalid", 32'(p0_rvalid), 32'h1);
    chk("l031_rdata", p0_rdata, 32'h0000_0011);

    // Half store into the upper half of word 5.
    tick(); drive(0, 1'b1, 16'h0016, 2'b01, 1'b0, 32'h0000_BEEF);
    @(negedge clk);
    chk("s032_mem_read", 32'(mem_read), 32'h1);
    tick(); idle_all();
    @(negedge clk);
    chk("s032_mem_write", 32'(mem_write), 32'h1);
    chk("s032_wdata", mem_write_data, 32'hBEEF_3344);
    chk("s032_wdone_early", 32'(p0_wdone), 32'h0);
    tick();
    @(negedge clk);
    chk("s032_wdone", 32'(p0_wdone), 32'h1);
    chk("s032_word5", mem_peek(5), 32'hBEEF_3344);

    // Back-to-back sub-word loads with both extensions.
    tick(); drive(0, 1'b0, 16'h0016, 2'b01, 1'b0, 32'h0);
    tick(); drive(0, 1'b0, 16'h0016, 2'b01, 1'b1, 32'h0);
    @(negedge clk);
    chk("ld_half_signed", p0_rdata, 32'hFFFF_BEEF);
    tick(); drive(0, 1'b0, 16'h0017, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    chk("ld_half_unsigned", p0_rdata, 32'h0000_BEEF);
    tick(); idle_all();
    @(negedge clk);
    chk("ld_byte_signed", p0_rdata, 32'hFFFF_FFBE);

    // DMA word store, then byte RMW into the same word, then size-11 word load.
    tick(); drive(1, 1'b1, 16'h0020, 2'b10, 1'b0, 32'hCAFE_F00D);
    @(negedge clk);
    chk("p1_word_store_write", 32'(mem_write), 32'h1);
    tick(); drive(1, 1'b1, 16'h0021, 2'b00, 1'b0, 32'h0000_0077);
    @(negedge clk);
    chk("p1_word_store_wdone", 32'(p1_wdone), 32'h1);
    tick(); idle_all();
    tick(); drive(1, 1'b0, 16'h0020, 2'b11, 1'b0, 32'h0);
    tick(); idle_all();
    @(negedge clk);
    chk("p1_rmw_readback", p1_rdata, 32'hCAFE_770D);

    // Misaligned word load on p1 and misaligned half store on p0.
    tick(); drive(1, 1'b0, 16'h0002, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    chk("e034_gnt", 32'(p1_gnt), 32'h1);
    chk("e034_no_strobe", 32'({mem_read, mem_write}), 32'h0);
    tick(); idle_all();
    @(negedge clk);
    chk("e034_err", 32'(p1_err), 32'h1);
    chk("e034_rvalid", 32'(p1_rvalid), 32'h1);
    chk("e034_rdata", p1_rdata, 32'h0);
    tick(); drive(0, 1'b1, 16'h0005, 2'b01, 1'b0, 32'h0000_1234);
    tick(); idle_all();
    @(negedge clk);
    chk("e_store_err", 32'(p0_err), 32'h1);
    chk("e_store_wdone", 32'(p0_wdone), 32'h1);

    // Reset landing in the RMW write cycle.
    tick(); drive(0, 1'b1, 16'h0014, 2'b00, 1'b0, 32'h0000_0099);
    @(negedge clk);
    chk("r035_mem_read", 32'(mem_read), 32'h1);
    tick(); idle_all(); reset = 1'b1;
    @(negedge clk);
    chk("r035_no_write", 32'(mem_write), 32'h0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("r035_no_wdone", 32'(p0_wdone), 32'h0);
    chk("r035_word5", mem_peek(5), 32'hBEEF_3344);
    tick(); drive(0, 1'b0, 16'h0014, 2'b10, 1'b0, 32'h0);
    tick(); idle_all();
    @(negedge clk);
    chk("r035_readback", p0_rdata, 32'hBEEF_3344);

    // Both ports requesting continuously from a cleared wait counter.
    tick();
    drive(0, 1'b0, 16'h0030, 2'b10, 1'b0, 32'h0);
    drive(1, 1'b0, 16'h0040, 2'b10, 1'b0, 32'h0);
    p1_first = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (p1_first != 0 && c == p1_first + 1) chk("a033_p0_after", 32'(p0_gnt), 32'h1);
      if (p1_gnt && p1_first == 0) p1_first = c;
      tick();
    end
    idle_all();
    chk("a033_p1_cycle", 32'(p1_first), 32'd5);

    // Three back-to-back word loads.
    nmr = 0;
    nrv = 0;
    tick(); drive(0, 1'b0, 16'h0014, 2'b10, 1'b0, 32'h0);
    @(negedge clk); nmr += int'(mem_read);
    tick(); drive(0, 1'b0, 16'h0020, 2'b10, 1'b0, 32'h0);
    @(negedge clk); nmr += int'(mem_read); nrv += int'(p0_rvalid);
    tick(); drive(0, 1'b0, 16'h0004, 2'b10, 1'b0, 32'h0);
    @(negedge clk); nmr += int'(mem_read); nrv += int'(p0_rvalid);
    tick(); idle_all();
    @(negedge clk); nrv += int'(p0_rvalid);
    chk("b036_mem_reads", 32'(nmr), 32'd3);
    chk("b036_rvalids", 32'(nrv), 32'd3);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: cycles port 1 may wait before it overrides port 0 priority.
REQ-002 SHALL have parameter ADDR_W, default 14: word-address width of the data memory.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports pN_req, pN_we, input, 1 bit each (N=0 CPU, N=1 DMA): request valid and store(1)/load(0).
REQ-006 SHALL have ports pN_addr, input, ADDR_W+2 bits: byte address.
REQ-007 SHALL have ports pN_size, input, 2 bits: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-008 SHALL have ports pN_unsigned, input, 1 bit: zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have ports pN_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have ports pN_gnt, output, 1 bit: request accepted this cycle.
REQ-011 SHALL have ports pN_rvalid, pN_wdone, pN_err, output, 1 bit each: load data valid, store complete, misalignment error.
REQ-012 SHALL have ports pN_rdata, output, 32 bits: extended load result.
REQ-013 SHALL have ports mem_read, mem_write, output, 1 bit each: data-memory strobes, never both 1.
REQ-014 SHALL have ports mem_address, output, ADDR_W bits, and mem_write_data, output, 32 bits: the byte address bits [ADDR_W+1:2] and the write word.
REQ-015 SHALL have port mem_read_data, input, 32 bits: memory read word, valid one cycle after mem_read.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_RESP, RMW_WR and ERR_RESP; a grant is permitted only in IDLE, LOAD_RESP or ERR_RESP.
REQ-017 SHALL give arbitration priority to port 0 unless the port 1 wait counter equals STARVE_LIMIT, in which case port 1 wins.
REQ-018 SHALL increment the wait counter each cycle p1_req=1 and p1 is not granted, saturating at STARVE_LIMIT, and clear it on p1_gnt.
REQ-019 SHALL assert at most one gnt per cycle, combinationally, in the same cycle as the accepted req.
REQ-020 SHALL handle an aligned load granted at cycle T as follows: mem_read=1 at T; at T+1, state LOAD_RESP, rvalid=1 to the owner, and rdata = byte/half lane selected by addr[1:0] and extended.
REQ-021 SHALL handle an aligned word store at T with mem_write=1 and mem_write_data=wdata at T, then wdone=1 at T+1.
REQ-022 SHALL handle a byte/half store at T by issuing mem_read at T, then in RMW_WR at T+1 driving mem_write with mem_read_data merged with the shifted wdata lanes, and pulsing wdone at T+2.
REQ-023 SHALL treat a half at addr[0]=1, or a word with addr[1:0]!=0, as misaligned: gnt=1 and no memory strobe at T, then ERR_RESP at T+1 with err=1, rvalid or wdone=1, and rdata=0.
REQ-024 SHALL route every response pulse only to the port recorded as owner at grant time.
REQ-025 SHALL keep all response outputs at 0 except during their single-cycle pulse.
REQ-026 SHALL permit back-to-back grants, so a load granted in LOAD_RESP issues mem_read in the same cycle the previous data returns.

Reset
REQ-027 SHALL, on reset, force state IDLE, wait counter 0, owner 0, and all gnt/rvalid/wdone/err/mem_read/mem_write outputs to 0, rdata to 0.
REQ-028 SHALL ensure that a reset asserted during RMW_WR suppresses mem_write, leaving memory unchanged and producing no wdone.

Structure
REQ-029 SHALL place the size encodings, FSM state encoding and default STARVE_LIMIT in shared package dmem_pkg.
REQ-030 SHALL implement lane merge (store) and lane extract/extend (load) in combinational sub-module dmem_byte_lane.

Verification
REQ-031 SHALL cover: mem word 5 = 0x11223344; p0 load byte signed at addr 0x0017 -> rvalid at T+1, rdata 0x00000011.
REQ-032 SHALL cover: p0 store half 0xBEEF at addr 0x0016 over word 5 = 0x11223344 -> mem_write at T+1 with data 0xBEEF3344, wdone at T+2.
REQ-033 SHALL cover: p0 and p1 requesting continuously -> p1 granted on the 5th cycle, counter cleared, p0 granted next.
REQ-034 SHALL cover: p1 word load at addr 0x0002 -> no mem strobe, p1_err=1 and p1_rvalid=1 at T+1, rdata 0.
REQ-035 SHALL cover: reset pulsed in the RMW_WR cycle -> mem_write stays 0, word unchanged, no wdone.
REQ-036 SHALL cover: three back-to-back p0 word loads -> mem_read high three consecutive cycles, rvalid high three consecutive cycles.
